// File: rtl/mmio_fifo_buffer.sv
`default_nettype none
// ============================================================================
// Module      : mmio_fifo_buffer
// Description : Synchronous FIFO between the AFU MMIO write decode and the
//               MMIO read mux. A host write pushes one word and a host read
//               pops one word. The popped word appears on rd_data one cycle
//               later, qualified by a one-cycle rd_valid pulse.
//               Optional macro MMIO_FIFO_ERR_STICKY_EN adds sticky
//               overflow/underflow flags (err_ovf / err_udf).
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_fifo_buffer #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
`ifdef MMIO_FIFO_ERR_STICKY_EN
    ,
    output logic              err_ovf,
    output logic              err_udf
`endif
);

    localparam int         c_PTR_W = $clog2(DEPTH);
    localparam [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_rd_valid;
    logic               w_push_ok;
    logic               w_pop_ok;

    // A full FIFO still accepts a write when a pop frees a slot on the same edge.
    assign full      = (r_count == c_DEPTH);
    assign empty     = (r_count == '0);
    assign w_push_ok = wr_en & (~full | rd_en);
    assign w_pop_ok  = rd_en & ~empty;

    assign count    = r_count;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

    // Storage array write port; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); occupancy tracks push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered read port: on a simultaneous push/pop at full the old word is
    // read because the array write lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop_ok;
            if (w_pop_ok) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end
        end
    end

`ifdef MMIO_FIFO_ERR_STICKY_EN
    logic r_err_ovf;
    logic r_err_udf;

    assign err_ovf = r_err_ovf;
    assign err_udf = r_err_udf;

    // Sticky flags for dropped writes and ignored reads; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (full & wr_en & ~rd_en) begin
                r_err_ovf <= 1'b1;
            end
            if (empty & rd_en) begin
                r_err_udf <= 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmio_fifo_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_fifo_buffer
// Description : Directed self-checking bench for mmio_fifo_buffer
//               (DEPTH=8, DATA_W=64). Inputs change and outputs are sampled
//               1 ns after the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_fifo_buffer;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [63:0] wr_data;
    logic        rd_en;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        full;
    logic        empty;
    logic [3:0]  count;
`ifdef MMIO_FIFO_ERR_STICKY_EN
    logic        err_ovf;
    logic        err_udf;
`endif

    int checks = 0;
    int errors = 0;

    mmio_fifo_buffer #(.DATA_W(64), .DEPTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (full),
        .empty    (empty),
        .count    (count)
`ifdef MMIO_FIFO_ERR_STICKY_EN
        ,
        .err_ovf  (err_ovf),
        .err_udf  (err_udf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d);
        wr_en = 1'b1; wr_data = d; rd_en = 1'b0;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        #12;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%b full=%b expected 1 0", empty, full); end
        checks++; if (rd_valid !== 1'b0 || rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd: got valid=%b data=%h expected 0 0", rd_valid, rd_data); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [63:0] exp [3];
        exp[0] = 64'hA1; exp[1] = 64'hB2; exp[2] = 64'hC3;
        for (int i = 0; i < 3; i++) push(exp[i]);
        checks++; if (count !== 4'd3 || empty !== 1'b0) begin errors++; $display("FAIL basic_count3: got count=%0d empty=%b expected 3 0", count, empty); end
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            checks++; if (rd_valid !== 1'b1 || rd_data !== exp[i]) begin errors++; $display("FAIL basic_pop%0d: got valid=%b data=%h expected 1 %h", i, rd_valid, rd_data, exp[i]); end
            tick();
            checks++; if (rd_valid !== 1'b0 || rd_data !== exp[i]) begin errors++; $display("FAIL basic_pulse%0d: got valid=%b data=%h expected 0 %h", i, rd_valid, rd_data, exp[i]); end
        end
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL basic_end: got count=%0d empty=%b expected 0 1", count, empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) push(64'(i));
        checks++; if (full !== 1'b1 || count !== 4'd8) begin errors++; $display("FAIL ovf_full: got full=%b count=%0d expected 1 8", full, count); end
        push(64'hFF);
        checks++; if (full !== 1'b1 || count !== 4'd8) begin errors++; $display("FAIL ovf_drop: got full=%b count=%0d expected 1 8", full, count); end
`ifdef MMIO_FIFO_ERR_STICKY_EN
        checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b expected 1", err_ovf); end
`endif
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            tick();
            checks++; if (rd_valid !== 1'b1 || rd_data !== 64'(i)) begin errors++; $display("FAIL ovf_pop%0d: got valid=%b data=%h expected 1 %h", i, rd_valid, rd_data, 64'(i)); end
        end
        rd_en = 1'b0;
        tick();
        checks++; if (empty !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 64'h7) begin errors++; $display("FAIL ovf_end: got empty=%b valid=%b data=%h expected 1 0 7", empty, rd_valid, rd_data); end
    endtask

    task automatic test_full_rw();
        logic [63:0] exp [8];
        for (int i = 0; i < 8; i++) push(64'(i));
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 64'h99;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 64'h0 || count !== 4'd8) begin errors++; $display("FAIL fullrw: got valid=%b data=%h count=%0d expected 1 0 8", rd_valid, rd_data, count); end
        for (int i = 0; i < 7; i++) exp[i] = 64'(i + 1);
        exp[7] = 64'h99;
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            tick();
            checks++; if (rd_valid !== 1'b1 || rd_data !== exp[i]) begin errors++; $display("FAIL fullrw_drain%0d: got valid=%b data=%h expected 1 %h", i, rd_valid, rd_data, exp[i]); end
        end
        rd_en = 1'b0;
        tick();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL fullrw_end: got count=%0d expected 0", count); end
    endtask

    task automatic test_underflow();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b0 || rd_data !== 64'h99 || count !== 4'd0) begin errors++; $display("FAIL udf_ignore: got valid=%b data=%h count=%0d expected 0 99 0", rd_valid, rd_data, count); end
`ifdef MMIO_FIFO_ERR_STICKY_EN
        checks++; if (err_udf !== 1'b1) begin errors++; $display("FAIL udf_err: got %b expected 1", err_udf); end
`endif
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 64'h55;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (count !== 4'd1 || rd_valid !== 1'b0 || rd_data !== 64'h99) begin errors++; $display("FAIL udf_rw: got count=%0d valid=%b data=%h expected 1 0 99", count, rd_valid, rd_data); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 64'h55 || count !== 4'd0) begin errors++; $display("FAIL udf_pop: got valid=%b data=%h count=%0d expected 1 55 0", rd_valid, rd_data, count); end
    endtask

    task automatic test_wrap();
        logic [63:0] sb [$];
        logic [63:0] exp;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                wr_en = 1'b1; rd_en = 1'b0; wr_data = 64'h1000 + 64'(i);
                sb.push_back(wr_data);
                tick();
            end else begin
                wr_en = 1'b0; rd_en = 1'b1;
                exp = sb.pop_front();
                tick();
                checks++; if (rd_valid !== 1'b1 || rd_data !== exp) begin errors++; $display("FAIL wrap_pop%0d: got valid=%b data=%h expected 1 %h", i, rd_valid, rd_data, exp); end
            end
            checks++; if (count > 4'd1) begin errors++; $display("FAIL wrap_count%0d: got %0d expected <=1", i, count); end
        end
        wr_en = 1'b0; rd_en = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        push(64'h11); push(64'h22); push(64'h33);
        rd_en = 1'b1;
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 64'h11) begin errors++; $display("FAIL mrst_pre: got valid=%b data=%h expected 1 11", rd_valid, rd_data); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL mrst_count: got count=%0d empty=%b full=%b expected 0 1 0", count, empty, full); end
        checks++; if (rd_valid !== 1'b0 || rd_data !== 64'h0) begin errors++; $display("FAIL mrst_rd: got valid=%b data=%h expected 0 0", rd_valid, rd_data); end
`ifdef MMIO_FIFO_ERR_STICKY_EN
        checks++; if (err_ovf !== 1'b0 || err_udf !== 1'b0) begin errors++; $display("FAIL mrst_err: got ovf=%b udf=%b expected 0 0", err_ovf, err_udf); end
`endif
        rd_en = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        checks++; if (empty !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL mrst_after: got empty=%b valid=%b expected 1 0", empty, rd_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_rw();
        test_underflow();
        test_wrap();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
